edge_line_unpacker: RTL and testbench

//  Downstream of the SSSP DMA read engine. Buffers the in-order 512-bit edge lines it delivers, unpacks each

---
 rtl/edge_pkg.sv | 28 ++
 rtl/edge_line_unpacker_if.sv | 29 ++
 rtl/sync_line_fifo.sv | 60 ++++++
 rtl/edge_line_unpacker.sv | 151 +++++++++++++++
 tb/tb_edge_line_unpacker.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge line unpacker: the packed edge
// record, the line geometry and the pass-control state encoding.
package edge_pkg;

  localparam int EDGES_PER_LINE = 8;
  localparam int EDGE_BITS      = 64;
  localparam int LINE_BITS      = EDGES_PER_LINE * EDGE_BITS;
  localparam int SLOT_BITS      = $clog2(EDGES_PER_LINE);

  typedef struct packed {
    logic [23:0] src;
    logic [23:0] dst;
    logic [15:0] weight;
  } t_edge;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } t_state;

  // Slot 0 sits in the least significant 64 bits of the line.
  function automatic t_edge line_slot(input logic [LINE_BITS-1:0] line,
                                      input logic [SLOT_BITS-1:0] slot);
    return line[int'(slot) * EDGE_BITS +: EDGE_BITS];
  endfunction

endpackage

// File: rtl/edge_line_unpacker_if.sv
// Bundle between the read engine / relax stage and the unpacker: pass control,
// line intake with drop back-pressure, and the edge record stream.
interface edge_line_unpacker_if;
  import edge_pkg::*;

  logic                 start;
  logic [31:0]          num_edges;
  logic [LINE_BITS-1:0] line_in;
  logic                 line_in_valid;
  logic                 drop;
  logic                 edge_valid;
  logic                 edge_ready;
  logic [23:0]          edge_src;
  logic [23:0]          edge_dst;
  logic [15:0]          edge_weight;
  logic                 done;
  logic                 overflow;

  modport master (
    output start, num_edges, line_in, line_in_valid, edge_ready,
    input  drop, edge_valid, edge_src, edge_dst, edge_weight, done, overflow
  );

  modport slave (
    input  start, num_edges, line_in, line_in_valid, edge_ready,
    output drop, edge_valid, edge_src, edge_dst, edge_weight, done, overflow
  );

endinterface

// File: rtl/sync_line_fifo.sv
// Single-clock FIFO with first-word fall-through head data and a flush that
// empties it in one cycle. Flush beats push/pop; push while full needs a pop.
module sync_line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count, so clearing 16 x 512 bits would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/edge_line_unpacker.sv
// Buffers 512-bit edge lines from the DMA read engine and streams their eight
// 64-bit records, one per cycle, to the relax stage; throttles the engine via drop.
module edge_line_unpacker
  import edge_pkg::*;
#(
  parameter int LINE_FIFO_DEPTH = 16,
  parameter int HIGH_WM         = 12,
  parameter int LOW_WM          = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  edge_line_unpacker_if.slave  bus
);

  localparam int                  CNT_BITS = $clog2(LINE_FIFO_DEPTH) + 1;
  localparam logic [CNT_BITS-1:0] HIGH_CNT = CNT_BITS'(HIGH_WM);
  localparam logic [CNT_BITS-1:0] LOW_CNT  = CNT_BITS'(LOW_WM);
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(EDGES_PER_LINE - 1);

  t_state               state;
  t_state               next_state;
  logic                 done_c;
  logic [31:0]          num_reg;
  logic [31:0]          issue_count;
  logic [31:0]          edge_count;
  logic [SLOT_BITS-1:0] slot;
  logic                 drop_q;
  logic                 overflow_q;
  logic                 edge_valid_q;
  t_edge                edge_q;

  logic [LINE_BITS-1:0] head;
  logic [CNT_BITS-1:0]  fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic                 load;
  logic                 handshake;
  logic                 enter_finish;

  assign handshake    = edge_valid_q && bus.edge_ready;
  assign push         = bus.line_in_valid && (state != ST_IDLE);
  // A record moves into the output register whenever the register is free or
  // draining this cycle, until the whole pass has been issued.
  assign load         = (state == ST_RUN) && !fifo_empty && (issue_count != num_reg) &&
                        (!edge_valid_q || bus.edge_ready);
  assign pop          = load && (slot == LAST_SLOT);
  assign enter_finish = (next_state == ST_FINISH) && (state != ST_FINISH);
  assign flush        = enter_finish;

  sync_line_fifo #(
    .WIDTH (LINE_BITS),
    .DEPTH (LINE_FIFO_DEPTH)
  ) u_line_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.line_in),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) next_state = (bus.num_edges == 32'd0) ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        if (handshake && (edge_count + 32'd1 == num_reg)) next_state = ST_FINISH;
      end
      ST_FINISH: begin
        done_c     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_reg     <= '0;
      issue_count <= '0;
      edge_count  <= '0;
      slot        <= '0;
    end else begin
      if ((state == ST_IDLE) && bus.start) num_reg <= bus.num_edges;
      if (enter_finish) begin
        issue_count <= '0;
        edge_count  <= '0;
        slot        <= '0;
      end else begin
        if (load) begin
          issue_count <= issue_count + 32'd1;
          slot        <= slot + 1'b1;
        end
        if (handshake) edge_count <= edge_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_valid_q <= 1'b0;
      edge_q       <= '0;
    end else if (enter_finish) begin
      edge_valid_q <= 1'b0;
    end else if (load) begin
      edge_valid_q <= 1'b1;
      edge_q       <= line_slot(head, slot);
    end else if (bus.edge_ready) begin
      edge_valid_q <= 1'b0;
    end
  end

  // Hysteresis on occupancy; keyed on next_state so drop reads 0 in IDLE/FINISH.
  always_ff @(posedge clk) begin
    if (reset)                        drop_q <= 1'b0;
    else if (next_state != ST_RUN)    drop_q <= 1'b0;
    else if (fifo_count >= HIGH_CNT)  drop_q <= 1'b1;
    else if (fifo_count <= LOW_CNT)   drop_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)                                        overflow_q <= 1'b0;
    else if (push && !flush && fifo_full && !pop)     overflow_q <= 1'b1;
  end

  assign bus.drop        = drop_q;
  assign bus.edge_valid  = edge_valid_q;
  assign bus.edge_src    = edge_q.src;
  assign bus.edge_dst    = edge_q.dst;
  assign bus.edge_weight = edge_q.weight;
  assign bus.done        = done_c;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_edge_line_unpacker.sv
// Self-checking bench for edge_line_unpacker: directed passes plus a random
// back-pressure run, all records scored against a queue built from the pushed lines.
module tb_edge_line_unpacker;
  import edge_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  edge_line_unpacker_if bus();

  edge_line_unpacker #(
    .LINE_FIFO_DEPTH (16),
    .HIGH_WM         (12),
    .LOW_WM          (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int    n_checks    = 0;
  int    n_fail      = 0;
  int    cyc         = 0;
  int    last_hs_cyc = -1;
  int    done_cyc    = -1;
  int    accepted    = 0;
  t_edge exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; score any record handshaken at that edge and make sure
  // a stalled record did not change underneath the consumer.
  task automatic tick();
    logic  hs;
    logic  stall;
    logic  rst_pre;
    t_edge rec;
    hs         = bus.edge_valid && bus.edge_ready;
    stall      = bus.edge_valid && !bus.edge_ready;
    rst_pre    = reset;
    rec.src    = bus.edge_src;
    rec.dst    = bus.edge_dst;
    rec.weight = bus.edge_weight;
    if (hs) last_hs_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (hs && !rst_pre) begin
      accepted++;
      if (exp_q.size() == 0) check("record_available", 64'(exp_q.size()), 64'd1);
      else                   check("record", 64'(rec), 64'(exp_q.pop_front()));
    end
    if (stall && !rst_pre) begin
      check("stall_valid", 64'(bus.edge_valid), 64'd1);
      check("stall_hold", {bus.edge_src, bus.edge_dst, bus.edge_weight}, 64'(rec));
    end
  endtask

  function automatic logic [LINE_BITS-1:0] seq_line(input int base);
    logic [LINE_BITS-1:0] l;
    t_edge e;
    for (int k = 0; k < EDGES_PER_LINE; k++) begin
      e.src    = 24'(base + k);
      e.dst    = 24'(base + k + 100);
      e.weight = 16'(base + k);
      l[k*EDGE_BITS +: EDGE_BITS] = e;
    end
    return l;
  endfunction

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < EDGES_PER_LINE; k++) l[k*EDGE_BITS +: EDGE_BITS] = {$urandom(), $urandom()};
    return l;
  endfunction

  task automatic expect_line(input logic [LINE_BITS-1:0] l, input int n_rec);
    for (int k = 0; k < n_rec; k++) exp_q.push_back(t_edge'(l[k*EDGE_BITS +: EDGE_BITS]));
  endtask

  task automatic push_line(input logic [LINE_BITS-1:0] l, input int n_rec);
    expect_line(l, n_rec);
    bus.line_in       = l;
    bus.line_in_valid = 1'b1;
    tick();
    bus.line_in_valid = 1'b0;
  endtask

  task automatic start_pass(input logic [31:0] n);
    bus.start     = 1'b1;
    bus.num_edges = n;
    accepted      = 0;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
    done_cyc = cyc;
    tick();
    check("done_width", 64'(bus.done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  64'(bus.edge_valid), 64'd0);
    check({tag, "_drop"},   64'(bus.drop), 64'd0);
    check({tag, "_done"},   64'(bus.done), 64'd0);
    check({tag, "_ovf"},    64'(bus.overflow), 64'd0);
    check({tag, "_fields"}, {bus.edge_src, bus.edge_dst, bus.edge_weight}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_BITS-1:0] l;
    int  n;
    int  idx;
    int  occ;
    bit  drop_m;
    bit  drop_d;

    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.num_edges     = '0;
    bus.line_in       = '0;
    bus.line_in_valid = 1'b0;
    bus.edge_ready    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1: two lines back-to-back, ready held, 16 sequential records.
    bus.edge_ready = 1'b1;
    start_pass(16);
    push_line(seq_line(0), 8);
    check("t1_latency_1", 64'(bus.edge_valid), 64'd0);
    push_line(seq_line(8), 8);
    check("t1_latency_2", 64'(bus.edge_valid), 64'd1);
    wait_done(100);
    check("t1_done_lag", 64'(done_cyc - last_hs_cyc), 64'd1);
    check("t1_all_seen", 64'(exp_q.size()), 64'd0);

    // 2: partial last line, then a fresh pass sees only new data.
    start_pass(11);
    push_line(seq_line(200), 8);
    push_line(seq_line(208), 3);
    wait_done(100);
    check("t2_all_seen", 64'(exp_q.size()), 64'd0);
    start_pass(8);
    push_line(seq_line(500), 8);
    wait_done(100);
    check("t2b_all_seen", 64'(exp_q.size()), 64'd0);

    // 3: drop hysteresis; rises after 12 buffered, falls after <=4 buffered.
    bus.edge_ready = 1'b0;
    start_pass(112);
    for (int i = 1; i <= 14; i++) begin
      push_line(rand_line(), 8);
      check("t3_drop_fill", 64'(bus.drop), 64'(i >= 13));
    end
    check("t3_no_ovf", 64'(bus.overflow), 64'd0);
    bus.edge_ready = 1'b1;
    drop_m = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      tick();
      n++;
      check("t3_drop_drain", 64'(bus.drop), 64'(drop_m));
      // A line leaves the FIFO once its last record enters the output register,
      // which with ready held is one record ahead of the accepted count.
      occ = 14 - (accepted + 1) / 8;
      if (occ >= 12)     drop_m = 1'b1;
      else if (occ <= 4) drop_m = 1'b0;
    end
    wait_done(10);
    check("t3_all_seen", 64'(exp_q.size()), 64'd0);

    // 4: random ready and an engine that honours drop one cycle late.
    start_pass(800);
    idx    = 0;
    drop_d = 1'b0;
    n      = 0;
    while (bus.done !== 1'b1 && n < 20000) begin
      bus.edge_ready = 1'($urandom_range(0, 1));
      if (idx < 100 && !drop_d && $urandom_range(0, 3) != 0) begin
        l = rand_line();
        expect_line(l, 8);
        bus.line_in       = l;
        bus.line_in_valid = 1'b1;
        idx++;
      end else begin
        bus.line_in_valid = 1'b0;
      end
      drop_d = bus.drop;
      tick();
      n++;
    end
    bus.line_in_valid = 1'b0;
    wait_done(10);
    check("t4_lines_sent", 64'(idx), 64'd100);
    check("t4_all_seen", 64'(exp_q.size()), 64'd0);
    check("t4_no_ovf", 64'(bus.overflow), 64'd0);

    // 5: empty pass, then reset in the middle of a buffered pass.
    bus.edge_ready = 1'b1;
    start_pass(0);
    check("t5_done", 64'(bus.done), 64'd1);
    check("t5_no_valid", 64'(bus.edge_valid), 64'd0);
    check("t5_no_drop", 64'(bus.drop), 64'd0);
    tick();
    check("t5_done_width", 64'(bus.done), 64'd0);
    bus.edge_ready = 1'b0;
    start_pass(100);
    repeat (5) push_line(rand_line(), 0);
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_reset");
    bus.edge_ready = 1'b1;
    start_pass(8);
    push_line(seq_line(900), 8);
    wait_done(100);
    check("t5_fresh_data", 64'(exp_q.size()), 64'd0);

    // 6: overrun the FIFO with drop ignored; overflow is sticky until reset.
    bus.edge_ready = 1'b0;
    start_pass(1000);
    for (int i = 1; i <= 17; i++) begin
      push_line(rand_line(), (i <= 16) ? 8 : 0);
      if (i == 16) check("t6_ovf_at_full", 64'(bus.overflow), 64'd0);
      if (i == 17) check("t6_ovf_set", 64'(bus.overflow), 64'd1);
    end
    bus.edge_ready = 1'b1;
    repeat (20) tick();
    check("t6_ovf_sticky", 64'(bus.overflow), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t6_ovf_cleared", 64'(bus.overflow), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
